// File: rtl/mem_responder_if.sv
// Data-side bus between the M stage and the memory responder.
// Address, store data and store strobe flow toward the responder; load data flows back.
interface mem_responder_if;
  logic [31:0] ALUOutM;
  logic [31:0] writeDataM;
  logic        memWriteM;
  logic [31:0] readDataM;

  modport master (
    output ALUOutM,
    output writeDataM,
    output memWriteM,
    input  readDataM
  );

  modport slave (
    input  ALUOutM,
    input  writeDataM,
    input  memWriteM,
    output readDataM
  );
endinterface

// File: rtl/mem_responder.sv
// Data-side memory responder: word RAM plus a small peripheral block
// (cycle counter, compare timer, GPIO output, sticky access-error flag).
// Loads are combinational from the address; stores commit on the rising edge.
module mem_responder #(
  parameter int unsigned RAM_AW = 10,
  parameter int unsigned GPIO_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_responder_if.slave      bus,
  output logic [GPIO_W-1:0]   gpioOut,
  output logic                timerIrq,
  output logic                memErr
);

  localparam logic [5:0] SelCycle  = 6'h00;
  localparam logic [5:0] SelCmp    = 6'h01;
  localparam logic [5:0] SelCtrl   = 6'h02;
  localparam logic [5:0] SelCnt    = 6'h03;
  localparam logic [5:0] SelGpio   = 6'h04;
  localparam logic [5:0] SelStatus = 6'h05;

  // Word RAM; deliberately not reset
  logic [31:0] r_ram [2**RAM_AW];

  // Peripheral state
  logic [31:0]       r_cycle;
  logic [31:0]       r_cmp, r_cmp_d;
  logic [31:0]       r_cnt, r_cnt_d;
  logic              r_en, r_en_d;
  logic              r_irq, r_irq_d;
  logic              r_auto, r_auto_d;
  logic [GPIO_W-1:0] r_gpio, r_gpio_d;
  logic              r_err, r_err_d;

  // Address decode
  logic              w_is_ram;
  logic              w_is_per;
  logic              w_aligned;
  logic              w_sel_valid;
  logic [5:0]        w_sel;
  logic [RAM_AW-1:0] w_widx;
  logic              w_ram_we;
  logic              w_per_we;
  logic              w_set_err;
  logic              w_match;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;

  assign w_wdata     = bus.writeDataM;
  assign w_is_ram    = (bus.ALUOutM[31:RAM_AW+2] == '0);
  assign w_is_per    = (bus.ALUOutM[31:8] == 24'h800000);
  assign w_aligned   = (bus.ALUOutM[1:0] == 2'b00);
  assign w_sel       = bus.ALUOutM[7:2];
  assign w_widx      = bus.ALUOutM[RAM_AW+1:2];
  assign w_sel_valid = (w_sel <= SelStatus);

  assign w_ram_we  = bus.memWriteM && w_aligned && w_is_ram;
  assign w_per_we  = bus.memWriteM && w_aligned && w_is_per;
  // Misaligned, unmapped, or undefined peripheral offset: dropped and flagged
  assign w_set_err = bus.memWriteM &&
                     (!w_aligned || (!w_is_ram && !w_is_per) || (w_is_per && !w_sel_valid));

  // Match is judged on the pre-write count
  assign w_match = r_en && (r_cnt == r_cmp);

  // RAM store port
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_widx] <= w_wdata;
    end
  end

  // Combinational load mux; low address bits are ignored on reads
  always_comb begin
    w_rdata = 32'h0;
    if (w_is_ram) begin
      w_rdata = r_ram[w_widx];
    end else if (w_is_per) begin
      unique case (w_sel)
        SelCycle:  w_rdata = r_cycle;
        SelCmp:    w_rdata = r_cmp;
        SelCtrl:   w_rdata = {29'h0, r_auto, r_irq, r_en};
        SelCnt:    w_rdata = r_cnt;
        SelGpio:   w_rdata = {{(32-GPIO_W){1'b0}}, r_gpio};
        SelStatus: w_rdata = {31'h0, r_err};
        default:   w_rdata = 32'h0;
      endcase
    end
  end

  assign bus.readDataM = w_rdata;

  // Next-state for timer, GPIO and error flag; later assignments carry priority
  always_comb begin
    r_cmp_d  = r_cmp;
    r_cnt_d  = r_cnt;
    r_en_d   = r_en;
    r_irq_d  = r_irq;
    r_auto_d = r_auto;
    r_gpio_d = r_gpio;
    r_err_d  = r_err;

    if (r_en) begin
      if (w_match) begin
        if (r_auto) r_cnt_d = 32'h0;
        else        r_en_d  = 1'b0;
      end else begin
        r_cnt_d = r_cnt + 32'd1;
      end
    end

    if (w_per_we) begin
      if (w_sel == SelCmp)  r_cmp_d = w_wdata;
      if (w_sel == SelCnt)  r_cnt_d = w_wdata;
      if (w_sel == SelGpio) r_gpio_d = w_wdata[GPIO_W-1:0];
      if (w_sel == SelCtrl) begin
        r_en_d   = w_wdata[0];
        r_auto_d = w_wdata[2];
        if (w_wdata[1]) r_irq_d = 1'b0;
      end
      if (w_sel == SelStatus && w_wdata[0]) r_err_d = 1'b0;
    end

    // Set beats W1C
    if (w_match)   r_irq_d = 1'b1;
    if (w_set_err) r_err_d = 1'b1;
  end

  // Peripheral state registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle <= 32'h0;
      r_cmp   <= 32'h0;
      r_cnt   <= 32'h0;
      r_en    <= 1'b0;
      r_irq   <= 1'b0;
      r_auto  <= 1'b0;
      r_gpio  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_cmp   <= r_cmp_d;
      r_cnt   <= r_cnt_d;
      r_en    <= r_en_d;
      r_irq   <= r_irq_d;
      r_auto  <= r_auto_d;
      r_gpio  <= r_gpio_d;
      r_err   <= r_err_d;
    end
  end

  assign gpioOut  = r_gpio;
  assign timerIrq = r_irq;
  assign memErr   = r_err;

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-side memory responder for the five-stage pipeline. It answers the M-stage data port: address from ALUOutM, store data from writeDataM, write strobe memWriteM, and load data on readDataM. The block decodes the address into a word RAM region and a peripheral register region. The peripheral region holds a free-running cycle counter, a compare timer with an interrupt flag, a GPIO output register and a sticky access-error flag.

## Interface
- RAM_AW, 10, RAM word-address width; RAM holds 2^RAM_AW 32-bit words at byte addresses 0 .. 4*2^RAM_AW-1
- GPIO_W, 16, width of the GPIO output register
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low; clears all registers, not RAM contents
- ALUOutM  input  32  byte address of the access
- writeDataM  input  32  store data
- memWriteM  input  1  store strobe; 1 = write this cycle
- readDataM  output  32  load data, combinational from ALUOutM
- gpioOut  output  GPIO_W  GPIO register value
- timerIrq  output  1  timer interrupt flag (CTRL bit1)
- memErr  output  1  sticky access-error flag (STATUS bit0)

## Operation
- Reads are always active; there is no read strobe. readDataM reflects the current ALUOutM in the same cycle.
- Region decode:
  - RAM when ALUOutM[31:RAM_AW+2]==0; word index is ALUOutM[RAM_AW+1:2].
  - Peripheral when ALUOutM[31:8]==24'h800000; register select is ALUOutM[7:2].
  - Anything else is unmapped.
- Peripheral registers, at byte offset from 0x8000_0000:
  - 0x00 CYCLE: read-only; writes are ignored and set no error.
  - 0x04 CMP: read/write.
  - 0x08 CTRL: bit0 EN, bit1 IRQ, bit2 AUTO. Bits 0 and 2 are plain writes. Bit1 is write-1-to-clear. Reads return zero in bits 31:3.
  - 0x0C CNT: read/write.
  - 0x10 GPIO: bits GPIO_W-1:0 are read/write; upper read bits are zero.
  - 0x14 STATUS: bit0 ERR, write-1-to-clear.
  - Other peripheral offsets read 0; writes to them set ERR.
- Errors:
  - A write to an unmapped address sets ERR and changes no state.
  - A write with ALUOutM[1:0]!=0 sets ERR and is dropped.
  - Reads never set ERR. A misaligned read ignores ALUOutM[1:0]. An unmapped read returns 32'h0.
- CYCLE increments by 1 every clock and wraps from 32'hFFFFFFFF to 0.
- Timer update, per rising edge, while EN=1:
  - If CNT==CMP: IRQ<=1. If AUTO=1 then CNT<=0; otherwise CNT holds and EN<=0 (one-shot).
  - Otherwise CNT<=CNT+1, wrapping at 2^32.
  - While EN=0, CNT holds.
- Priority when events coincide in one cycle:
  - A CPU write to CNT overrides increment and reload. The match is evaluated on the pre-write CNT.
  - A CPU write to CTRL.EN overrides the one-shot clear.
  - An IRQ set by a match wins over a W1C of IRQ in the same cycle. The same rule applies to ERR set versus ERR clear.

## Timing
- Load latency is zero cycles: combinational RAM/register read feeds the W-stage register.
- A store commits on the rising edge that ends the M cycle. A read of the same address in the next cycle returns the new value.
- A same-cycle read of the address being written returns the old value.
- CYCLE reads N during the Nth cycle after rst deasserts, counting the first post-reset edge as 1.
- The timer match raises timerIrq one edge after CNT==CMP is present with EN=1.
- Reset values: readDataM follows the decode of ALUOutM; gpioOut=0, timerIrq=0, memErr=0; CYCLE, CMP, CNT and CTRL are 0.
- Asserting rst mid-operation clears every register immediately. It does not wait for a clock edge.
- RAM contents are not reset and are undefined until written.

## Test plan
- RAM write/read:
  - Stimulus: write 0x12345678 to 0x0000_0010, then read 0x10 the next cycle; also read 0x10 in the write cycle.
  - Required: 0x12345678 on the next-cycle read; the old value on the same-cycle read; memErr stays 0.
- Error handling:
  - Stimulus: write to 0x0000_0013, then to 0x4000_0000; then write 1 to STATUS.
  - Required: both writes are dropped, RAM is unchanged, and memErr=1 after the first; after the STATUS write, memErr=0.
- One-shot timer:
  - Stimulus: write CMP=5, CNT=0, CTRL=0x1.
  - Required: timerIrq rises 6 edges after the CTRL write edge; EN reads 0 afterwards; CNT holds 5.
- Auto-reload timer:
  - Stimulus: write CMP=3, CTRL=0x5.
  - Required: IRQ is set on each match; CNT sequence is 0,1,2,3,0,1...; a W1C of IRQ coincident with a match leaves IRQ=1.
- Reset and CYCLE:
  - Stimulus: run 100 cycles, assert rst between edges for 2 cycles, then release.
  - Required: gpioOut, timerIrq, memErr and CYCLE go to 0 immediately; a CYCLE read in the 3rd post-release cycle returns 3; CYCLE wraps when forced near 32'hFFFFFFFF via a reset-free run of the bench model.
- GPIO:
  - Stimulus: write 0xFFFF_A5A5 to 0x8000_0010.
  - Required: gpioOut=16'hA5A5 after the edge; a read returns 0x0000_A5A5.
